// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the ALU-control decode that drives it.
// Holds the 4-bit operation codes understood by alu_core.
package alu_pkg;

   localparam int unsigned ALU_OP_W = 4;

   localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0000;
   localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0001;
   localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0010;
   localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0110;
   localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b0111;
   localparam logic [ALU_OP_W-1:0] ALU_NOR  = 4'b1100;
   localparam logic [ALU_OP_W-1:0] ALU_NAND = 4'b1101;

endpackage

// File: rtl/alu_core.sv
// Combinational arithmetic/logic core.
// Ports:
//   ALUControl - operation select (alu_pkg opcodes)
//   A, B       - operands; signed only for SLT
//   alu_out_d  - next result (unregistered)
//   zero_d     - next zero flag, 1 when alu_out_d == 0
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic [ALU_OP_W-1:0] ALUControl,
   input  logic [WIDTH-1:0]    A,
   input  logic [WIDTH-1:0]    B,
   output logic [WIDTH-1:0]    alu_out_d,
   output logic                zero_d
);

   logic slt;

   // Native signed compare stays correct when A - B would overflow.
   assign slt = ($signed(A) < $signed(B));

   always_comb begin
      alu_out_d = '0;
      case (ALUControl)
         ALU_AND:  alu_out_d = A & B;
         ALU_OR:   alu_out_d = A | B;
         ALU_ADD:  alu_out_d = A + B;
         ALU_SUB:  alu_out_d = A - B;
         ALU_SLT:  alu_out_d = {{(WIDTH-1){1'b0}}, slt};
         ALU_NOR:  alu_out_d = ~(A | B);
         ALU_NAND: alu_out_d = ~(A & B);
         default:  alu_out_d = '0;
      endcase
   end

   assign zero_d = (alu_out_d == '0);

endmodule

// File: rtl/alu.sv
// Registered ALU: alu_core result and zero flag captured every rising edge.
// Ports:
//   clk, rst   - clock; asynchronous active-high reset (ALUOut=0, Zero=1)
//   ALUControl - operation select
//   A, B       - operands
//   ALUOut     - registered result, one cycle after the operands
//   Zero       - registered flag, equals (ALUOut == 0)
module alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ALU_OP_W-1:0] ALUControl,
   input  logic [WIDTH-1:0]    A,
   input  logic [WIDTH-1:0]    B,
   output logic [WIDTH-1:0]    ALUOut,
   output logic                Zero
);

   logic [WIDTH-1:0] alu_out_d, alu_out_q;
   logic             zero_d, zero_q;

   alu_core #(
      .WIDTH (WIDTH)
   ) u_alu_core (
      .ALUControl (ALUControl),
      .A          (A),
      .B          (B),
      .alu_out_d  (alu_out_d),
      .zero_d     (zero_d)
   );

   // Reset value keeps Zero consistent with ALUOut == 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_out_q <= '0;
         zero_q    <= 1'b1;
      end else begin
         alu_out_q <= alu_out_d;
         zero_q    <= zero_d;
      end
   end

   assign ALUOut = alu_out_q;
   assign Zero   = zero_q;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

   logic        clk;
   logic        rst;
   logic [3:0]  ALUControl;
   logic [15:0] A;
   logic [15:0] B;
   logic [15:0] ALUOut;
   logic        Zero;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;

   alu #(
      .WIDTH (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ALUControl (ALUControl),
      .A          (A),
      .B          (B),
      .ALUOut     (ALUOut),
      .Zero       (Zero)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // Reference model straight from the opcode table.
   function automatic logic [15:0] model(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
      int sa, sb;
      logic [15:0] r;
      sa = int'($signed(a));
      sb = int'($signed(b));
      case (op)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0010: r = 16'((sa + sb) & 32'hFFFF);
         4'b0110: r = 16'((sa - sb) & 32'hFFFF);
         4'b0111: r = (sa < sb) ? 16'd1 : 16'd0;
         4'b1100: r = ~(a | b);
         4'b1101: r = ~(a & b);
         default: r = 16'd0;
      endcase
      return r;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
      end
   endtask

   // Cycle compare process: expectation taken from inputs present at the edge.
   logic [15:0] exp_out;
   always @(posedge clk) begin
      exp_out = rst ? 16'd0 : model(ALUControl, A, B);
      #1;
      if (chk_en) begin
         check("cyc_out", ALUOut, exp_out);
         check("cyc_zero", {15'd0, Zero}, {15'd0, exp_out == 16'd0});
         check("cyc_inv", {15'd0, Zero}, {15'd0, ALUOut == 16'd0});
      end
   end

   task automatic apply(input string name, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] eo, input logic ez);
      @(negedge clk);
      ALUControl = op;
      A = a;
      B = b;
      @(posedge clk);
      #2;
      check(name, ALUOut, eo);
      check({name, "_z"}, {15'd0, Zero}, {15'd0, ez});
   endtask

   initial begin
      rst = 1;
      ALUControl = 4'b0010;
      A = 16'd3;
      B = 16'd4;
      #1;
      check("rst_out", ALUOut, 16'd0);
      check("rst_zero", {15'd0, Zero}, 16'd1);

      // Pin the model itself.
      check("mdl_nor", model(4'b1100, 16'd5, 16'd2), 16'hFFF8);
      check("mdl_slt_ovf", model(4'b0111, 16'h8000, 16'h7FFF), 16'd1);
      check("mdl_sub_wrap", model(4'b0110, 16'h8000, 16'd1), 16'h7FFF);

      @(negedge clk);
      rst = 0;
      chk_en = 1;

      apply("and", 4'b0000, 16'd7, 16'd1, 16'd1, 1'b0);
      apply("or", 4'b0001, 16'd5, 16'd2, 16'd7, 1'b0);
      apply("nor", 4'b1100, 16'd5, 16'd2, 16'hFFF8, 1'b0);
      apply("nand", 4'b1101, 16'd5, 16'd2, 16'hFFFF, 1'b0);
      apply("add1", 4'b0010, 16'd4, 16'd2, 16'd6, 1'b0);
      apply("add2", 4'b0010, 16'd7, 16'd1, 16'd8, 1'b0);
      apply("sub1", 4'b0110, 16'd5, 16'd3, 16'd2, 1'b0);
      apply("sub2", 4'b0110, 16'd15, 16'd1, 16'd14, 1'b0);
      apply("add_wrap", 4'b0010, 16'h7FFF, 16'd1, 16'h8000, 1'b0);
      apply("sub_zero", 4'b0110, 16'd3, 16'd3, 16'd0, 1'b1);
      apply("slt1", 4'b0111, 16'd5, 16'd1, 16'd0, 1'b1);
      apply("slt2", 4'b0111, 16'd14, 16'd15, 16'd1, 1'b0);
      apply("slt_neg", 4'b0111, 16'hFFFF, 16'd1, 16'd1, 1'b0);
      apply("slt_ovf1", 4'b0111, 16'h8000, 16'h7FFF, 16'd1, 1'b0);
      apply("slt_ovf2", 4'b0111, 16'h7FFF, 16'h8000, 16'd0, 1'b1);
      apply("undef", 4'b1111, 16'd5, 16'd2, 16'd0, 1'b1);

      // Asynchronous reset between edges.
      apply("pre_rst", 4'b0001, 16'd5, 16'd2, 16'd7, 1'b0);
      #2;
      rst = 1;
      #1;
      check("async_out", ALUOut, 16'd0);
      check("async_zero", {15'd0, Zero}, 16'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ALUControl = 4'b0001;
         A = 16'($urandom_range(1, 16'hFFFF));
         B = 16'($urandom);
         @(posedge clk);
         #2;
         check("hold_out", ALUOut, 16'd0);
         check("hold_zero", {15'd0, Zero}, 16'd1);
      end
      @(negedge clk);
      rst = 0;
      apply("release", 4'b0010, 16'd4, 16'd2, 16'd6, 1'b0);

      // Back-to-back random operations, checked by the compare process.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         case ($urandom_range(0, 7))
            0: ALUControl = 4'b0000;
            1: ALUControl = 4'b0001;
            2: ALUControl = 4'b0010;
            3: ALUControl = 4'b0110;
            4: ALUControl = 4'b0111;
            5: ALUControl = 4'b1100;
            6: ALUControl = 4'b1101;
            default: ALUControl = 4'($urandom);
         endcase
         A = 16'($urandom);
         B = ($urandom_range(0, 3) == 0) ? A : 16'($urandom);
      end
      @(posedge clk);
      #3;
      chk_en = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
